// File: rtl/pipelined_addsub.sv
// Valid/ready add/subtract unit whose carry chain is cut into STAGES registered segments.
// Each stage finishes one SEG-bit slice and forwards the remaining operand bits with its carry.
module pipelined_addsub #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int SEG  = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   logic [WIDTH-1:0] r_a   [STAGES];
   logic [WIDTH-1:0] r_b   [STAGES];
   logic [WIDTH-1:0] r_sum [STAGES];
   logic             r_c   [STAGES];
   logic [STAGES-1:0] r_vld;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;

   logic             w_advance;
   logic [WIDTH-1:0] w_a_in   [STAGES];
   logic [WIDTH-1:0] w_b_in   [STAGES];
   logic [WIDTH-1:0] w_sum_in [STAGES];
   logic [WIDTH-1:0] w_sum_nx [STAGES];
   logic             w_c_in   [STAGES];
   logic             w_co     [STAGES];
   logic             w_v_in   [STAGES];
   logic [SEG:0]     w_seg;
   logic             w_msb_c;
   logic             w_unused;

   assign w_advance = !r_vld[LAST] || out_ready;

   // Stage 0 takes the raw operands; subtract is folded in as a + ~b + 1.
   always_comb begin
      w_seg       = '0;
      w_a_in[0]   = a;
      w_b_in[0]   = b ^ {WIDTH{sub}};
      w_c_in[0]   = sub | cin;
      w_sum_in[0] = '0;
      w_v_in[0]   = in_valid;
      for (int s = 1; s < STAGES; s++) begin
         w_a_in[s]   = r_a[s-1];
         w_b_in[s]   = r_b[s-1];
         w_c_in[s]   = r_c[s-1];
         w_sum_in[s] = r_sum[s-1];
         w_v_in[s]   = r_vld[s-1];
      end
      for (int s = 0; s < STAGES; s++) begin
         w_seg = {1'b0, w_a_in[s][s*SEG +: SEG]} + {1'b0, w_b_in[s][s*SEG +: SEG]}
               + {{SEG{1'b0}}, w_c_in[s]};
         w_sum_nx[s]                = w_sum_in[s];
         w_sum_nx[s][s*SEG +: SEG]  = w_seg[SEG-1:0];
         w_co[s]                    = w_seg[SEG];
      end
   end

   // Carry into the MSB recovered from the MSB sum bit and its operand bits.
   assign w_msb_c = w_sum_nx[LAST][WIDTH-1] ^ w_a_in[LAST][WIDTH-1] ^ w_b_in[LAST][WIDTH-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld  <= '0;
         r_cout <= 1'b0;
         r_ovf  <= 1'b0;
         r_zero <= 1'b0;
         for (int s = 0; s < STAGES; s++) begin
            r_a[s]   <= '0;
            r_b[s]   <= '0;
            r_sum[s] <= '0;
            r_c[s]   <= 1'b0;
         end
      end else if (w_advance) begin
         for (int s = 0; s < STAGES; s++) begin
            r_vld[s] <= w_v_in[s];
            // Data only moves with a valid token so bubbles never disturb the outputs.
            if (w_v_in[s]) begin
               r_a[s]   <= w_a_in[s];
               r_b[s]   <= w_b_in[s];
               r_sum[s] <= w_sum_nx[s];
               r_c[s]   <= w_co[s];
            end
         end
         if (w_v_in[LAST]) begin
            r_cout <= w_co[LAST];
            r_ovf  <= w_msb_c ^ w_co[LAST];
            r_zero <= ~|w_sum_nx[LAST];
         end
      end
   end

   always_comb begin
      w_unused = 1'b0;
      for (int s = 0; s < STAGES; s++)
         w_unused = w_unused ^ (^r_a[s]) ^ (^r_b[s]) ^ r_c[s] ^ (^w_a_in[s]) ^ (^w_b_in[s]);
   end

   assign in_ready  = w_advance;
   assign out_valid = r_vld[LAST];
   assign sum       = r_sum[LAST];
   assign cout      = r_cout;
   assign ovf       = r_ovf;
   assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: four configurations share one stimulus stream,
// each with its own expected-result queue filled on acceptance and drained by a monitor.
module tb_pipelined_addsub;

   typedef struct packed {
      logic [31:0] s;
      logic        co;
      logic        ov;
      logic        z;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        cin = 1'b0;
   logic        sub = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] a = '0;
   logic [31:0] b = '0;

   logic        rdy  [4];
   logic        ovv  [4];
   logic        cov  [4];
   logic        ovfv [4];
   logic        zv   [4];
   logic [31:0] smv  [4];
   int          n_out   [4] = '{default: 0};
   int          max_run [4] = '{default: 0};
   int          pend    [4] = '{default: 0};

   int n_vec = 0;
   int n_err = 0;
   int n_chk = 0;

   always #5 clk = ~clk;

   // Reference: plain integer arithmetic on width-masked operands.
   function automatic exp_t model(int w, logic [31:0] x, logic [31:0] y, logic c, logic s);
      longint unsigned mask, xv, yv, full;
      longint          sx, sy, sr, smax, smin;
      exp_t            e;
      mask = (64'd1 << w) - 1;
      xv   = {32'd0, x} & mask;
      yv   = {32'd0, y} & mask;
      sx   = ((xv >> (w-1)) & 1) != 0 ? longint'(xv) - longint'(mask) - 1 : longint'(xv);
      sy   = ((yv >> (w-1)) & 1) != 0 ? longint'(yv) - longint'(mask) - 1 : longint'(yv);
      smax = longint'(mask >> 1);
      smin = -smax - 1;
      if (s) begin
         full = (xv - yv) & mask;
         e.co = (xv >= yv);
         sr   = sx - sy;
      end else begin
         full = xv + yv + {63'd0, c};
         e.co = (full > mask);
         sr   = sx + sy + longint'({63'd0, c});
         full = full & mask;
      end
      e.s  = full[31:0];
      e.ov = (sr > smax) || (sr < smin);
      e.z  = (full == 0);
      return e;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int W = (g == 2) ? 16 : (g == 3) ? 32 : 8;
      localparam int S = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 8;
      logic [W-1:0] w_sum;
      logic         w_rdy, w_ov, w_co, w_ovf, w_z;

      pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_ready  (w_rdy),
         .a         (a[W-1:0]),
         .b         (b[W-1:0]),
         .cin       (cin),
         .sub       (sub),
         .out_valid (w_ov),
         .out_ready (out_ready),
         .sum       (w_sum),
         .cout      (w_co),
         .ovf       (w_ovf),
         .zero      (w_z)
      );

      assign rdy[g]  = w_rdy;
      assign ovv[g]  = w_ov;
      assign cov[g]  = w_co;
      assign ovfv[g] = w_ovf;
      assign zv[g]   = w_z;
      assign smv[g]  = 32'(w_sum);

      exp_t q[$];
      exp_t e, got, held;
      logic hold;
      int   run;

      // Monitor: samples one time unit before each rising edge.
      initial begin
         hold = 1'b0;
         run  = 0;
         forever begin
            @(negedge clk);
            #4;
            got = {32'(w_sum), w_co, w_ovf, w_z};
            if (rst) begin
               q.delete();
               hold = 1'b0;
               run  = 0;
            end else begin
               if (w_ov && hold) begin
                  n_chk++;
                  if (got !== held) begin
                     n_err++;
                     $display("FAIL hold_stable dut%0d: got %h want %h", g, got, held);
                  end
               end
               if (w_ov && out_ready) begin
                  n_chk++;
                  if (q.size() == 0) begin
                     n_err++;
                     $display("FAIL spurious_result dut%0d: got %h want no result", g, got);
                  end else begin
                     e = q.pop_front();
                     if (got !== e) begin
                        n_err++;
                        $display("FAIL result dut%0d: got %h want %h", g, got, e);
                     end
                  end
                  n_out[g]++;
                  run++;
                  if (run > max_run[g]) max_run[g] = run;
               end else begin
                  run = 0;
               end
               hold = w_ov && !out_ready;
               held = got;
               if (in_valid && w_rdy) begin
                  q.push_back(model(W, a, b, cin, sub));
                  n_vec++;
               end
            end
            pend[g] = q.size();
         end
      end
   end

   task automatic send(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s);
      int n;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      a = x; b = y; cin = c; sub = s;
      #1;
      while (!rdy[0] && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("send_accept", 32'(rdy[0]), 1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "timeout");
   end

   initial begin
      int o0;
      int o[4];
      rst = 1'b1;
      in_valid = 1'b1;
      a = 32'hFFFF_FFFF; b = 32'h1; cin = 1'b0; sub = 1'b0;
      out_ready = 1'b1;
      #7;
      for (int i = 0; i < 4; i++) begin
         chk("rst_out_valid", 32'(ovv[i]), 0);
         chk("rst_sum", smv[i], 0);
         chk("rst_flags", {29'd0, cov[i], ovfv[i], zv[i]}, 0);
         chk("rst_in_ready", 32'(rdy[i]), 1);
      end
      #5;
      rst = 1'b0;

      // Literal checks on the 8-bit, 2-stage instance (and latency-1 instance).
      fork
         begin
            #4;
            chk("lat2_not_yet", 32'(ovv[0]), 0);
            chk("lat1_valid", 32'(ovv[1]), 1);
            chk("lat1_sum", smv[1], 0);
            #10;
            chk("wrap_valid", 32'(ovv[0]), 1);
            chk("wrap_sum", smv[0], 32'h00);
            chk("wrap_flags", {29'd0, cov[0], ovfv[0], zv[0]}, 3'b101);
            #10;
            chk("add_ovf_sum", smv[0], 32'h80);
            chk("add_ovf_flags", {29'd0, cov[0], ovfv[0], zv[0]}, 3'b010);
            #10;
            chk("sub_ovf_sum", smv[0], 32'h7F);
            chk("sub_ovf_flags", {29'd0, cov[0], ovfv[0], zv[0]}, 3'b110);
            #10;
            chk("sub_zero_sum", smv[0], 32'h00);
            chk("sub_zero_flags", {29'd0, cov[0], ovfv[0], zv[0]}, 3'b101);
         end
      join_none

      send(32'h7F, 32'h01, 1'b0, 1'b0);
      send(32'h80, 32'h01, 1'b0, 1'b1);
      send(32'h05, 32'h05, 1'b1, 1'b1);
      send(32'h7FFF, 32'h1, 1'b0, 1'b0);
      send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
      send(32'h8000_0000, 32'h1, 1'b1, 1'b1);
      send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
      idle(12);

      // Streaming: 16 back-to-back operations.
      for (int i = 0; i < 4; i++) begin
         max_run[i] = 0;
         o[i] = n_out[i];
      end
      for (int i = 0; i < 16; i++)
         send($urandom, $urandom, 1'($urandom), 1'($urandom));
      idle(12);
      for (int i = 0; i < 4; i++) begin
         chk("stream_count", 32'(n_out[i] - o[i]), 16);
         chk("stream_consecutive", 32'(max_run[i] >= 16), 1);
      end

      // Backpressure on the 2-stage instance.
      o0 = n_out[0];
      @(negedge clk);
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 3; i++)
               send($urandom, $urandom, 1'($urandom), 1'($urandom));
            idle(1);
         end
         begin
            repeat (5) @(negedge clk);
            #2;
            chk("bp_in_ready_low", 32'(rdy[0]), 0);
            chk("bp_out_valid", 32'(ovv[0]), 1);
            chk("bp_no_output", 32'(n_out[0] - o0), 0);
            @(negedge clk);
            out_ready = 1'b1;
         end
      join
      idle(10);
      chk("bp_count", 32'(n_out[0] - o0), 3);

      // Reset with operations in flight.
      send($urandom, $urandom, 1'($urandom), 1'($urandom));
      send($urandom, $urandom, 1'($urandom), 1'($urandom));
      @(posedge clk);
      #2;
      rst = 1'b1;
      in_valid = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         o[i] = n_out[i];
         chk("midrst_out_valid", 32'(ovv[i]), 0);
         chk("midrst_sum", smv[i], 0);
         chk("midrst_flags", {29'd0, cov[i], ovfv[i], zv[i]}, 0);
         chk("midrst_in_ready", 32'(rdy[i]), 1);
      end
      #10;
      rst = 1'b0;
      idle(12);
      for (int i = 0; i < 4; i++)
         chk("no_stale", 32'(n_out[i] - o[i]), 0);

      // Random traffic with bubbles and random backpressure.
      repeat (300) begin
         @(negedge clk);
         in_valid  = ($urandom % 4) != 0;
         a         = $urandom;
         b         = $urandom;
         cin       = 1'($urandom);
         sub       = 1'($urandom);
         out_ready = ($urandom % 3) != 0;
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      idle(20);
      for (int i = 0; i < 4; i++)
         chk("drain_empty", 32'(pend[i]), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
